// File: rtl/trap_unit.sv
// Trap/return handler: latches interrupt edges, arbitrates uret/ecall/irq,
// drives the fetch redirect and keeps a 4-deep nested return stack.
module trap_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ECALL_VEC = 32'h0000_0100,
    parameter logic [ADDR_W-1:0] IRQ_VEC0  = 32'h0000_0200,
    parameter logic [ADDR_W-1:0] IRQ_VEC1  = 32'h0000_0300,
    parameter logic [ADDR_W-1:0] IRQ_VEC2  = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ecall,
    input  logic              uret,
    input  logic [2:0]        irq_req,
    input  logic              irq_en,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        cur_level,
    output logic [2:0]        pending,
    output logic [2:0]        depth,
    output logic              stack_err
);

    localparam int unsigned STK_N = 4;

    logic [2:0]        r_irq_prev;
    logic [2:0]        r_pending;
    logic [1:0]        r_level;
    logic [2:0]        r_depth;
    logic              r_err;
    logic [ADDR_W-1:0] r_stk_pc  [STK_N];
    logic [1:0]        r_stk_lvl [STK_N];

    logic [2:0] w_edge;
    logic [2:0] w_elig;
    logic [2:0] w_take;
    logic [1:0] w_top;
    logic [1:0] w_new_level;
    logic       w_room;
    logic       w_nonempty;
    logic       w_push;
    logic       w_pop;
    logic       w_err_set;

    // Event arbitration: uret beats ecall beats interrupt, one event per cycle.
    always_comb begin
        w_edge      = irq_req & ~r_irq_prev;
        w_room      = (r_depth < 3'(STK_N));
        w_nonempty  = (r_depth != 3'd0);
        w_top       = r_depth[1:0] - 2'd1;
        for (int i = 0; i < 3; i++) begin
            w_elig[i] = r_pending[i] & irq_en & w_room & (r_level < 2'(i + 1));
        end
        redirect    = 1'b0;
        redirect_pc = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        w_take      = 3'b000;
        w_new_level = r_level;

        if (uret) begin
            if (w_nonempty) begin
                redirect    = 1'b1;
                redirect_pc = r_stk_pc[w_top];
                w_pop       = 1'b1;
            end else begin
                w_err_set   = 1'b1;
            end
        end else if (ecall) begin
            if (w_room) begin
                redirect    = 1'b1;
                redirect_pc = ECALL_VEC;
                w_push      = 1'b1;
            end else begin
                w_err_set   = 1'b1;
            end
        end else if (w_elig[2]) begin
            redirect    = 1'b1;
            redirect_pc = IRQ_VEC2;
            w_push      = 1'b1;
            w_take      = 3'b100;
            w_new_level = 2'd3;
        end else if (w_elig[1]) begin
            redirect    = 1'b1;
            redirect_pc = IRQ_VEC1;
            w_push      = 1'b1;
            w_take      = 3'b010;
            w_new_level = 2'd2;
        end else if (w_elig[0]) begin
            redirect    = 1'b1;
            redirect_pc = IRQ_VEC0;
            w_push      = 1'b1;
            w_take      = 3'b001;
            w_new_level = 2'd1;
        end
    end

    // A fresh edge re-pends even when the same source is taken this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_prev <= 3'b000;
            r_pending  <= 3'b000;
            r_level    <= 2'd0;
            r_depth    <= 3'd0;
            r_err      <= 1'b0;
            for (int i = 0; i < STK_N; i++) begin
                r_stk_pc[i]  <= '0;
                r_stk_lvl[i] <= 2'd0;
            end
        end else begin
            r_irq_prev <= irq_req;
            r_pending  <= (r_pending & ~w_take) | w_edge;
            r_err      <= r_err | w_err_set;
            if (w_push) begin
                r_stk_pc[r_depth[1:0]]  <= pc_next;
                r_stk_lvl[r_depth[1:0]] <= r_level;
                r_depth                 <= r_depth + 3'd1;
                r_level                 <= w_new_level;
            end else if (w_pop) begin
                r_depth <= r_depth - 3'd1;
                r_level <= r_stk_lvl[w_top];
            end
        end
    end

    assign cur_level = r_level;
    assign pending   = r_pending;
    assign depth     = r_depth;
    assign stack_err = r_err;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: reset, single/nested interrupts, ecall
// collisions, stack limits, enable gating and held-request edge detection.
module tb_trap_unit;

    logic        clk;
    logic        rst_n;
    logic        ecall;
    logic        uret;
    logic [2:0]  irq_req;
    logic        irq_en;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  cur_level;
    logic [2:0]  pending;
    logic [2:0]  depth;
    logic        stack_err;

    int n_chk  = 0;
    int n_fail = 0;

    trap_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ecall       (ecall),
        .uret        (uret),
        .irq_req     (irq_req),
        .irq_en      (irq_en),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .cur_level   (cur_level),
        .pending     (pending),
        .depth       (depth),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ecall = 1'b0; uret = 1'b0; irq_req = 3'b000;
        irq_en = 1'b0; pc_next = 32'h0;
        step(); step();
        rst_n = 1'b1;
        settle();
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_level", 32'(cur_level), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);

        // Single interrupt on source 0, then return.
        irq_en = 1'b1; pc_next = 32'h40; irq_req = 3'b001;
        step();
        irq_req = 3'b000; settle();
        chk("single_pending", 32'(pending), 32'b001);
        chk("single_redirect", 32'(redirect), 32'd1);
        chk("single_vec", redirect_pc, 32'h200);
        step();
        chk("single_level", 32'(cur_level), 32'd1);
        chk("single_depth", 32'(depth), 32'd1);
        chk("single_pend_clr", 32'(pending), 32'd0);
        chk("single_idle", 32'(redirect), 32'd0);
        pc_next = 32'h244; uret = 1'b1; settle();
        chk("single_ret_pc", redirect_pc, 32'h40);
        step();
        uret = 1'b0; settle();
        chk("single_ret_level", 32'(cur_level), 32'd0);
        chk("single_ret_depth", 32'(depth), 32'd0);

        // Nesting: level 1, pre-empted by source 2, source 1 masked until return.
        pc_next = 32'h50; irq_req = 3'b001;
        step();
        irq_req = 3'b000;
        step();
        pc_next = 32'h204; irq_req = 3'b100;
        step();
        irq_req = 3'b000; settle();
        chk("nest_vec2", redirect_pc, 32'h400);
        step();
        chk("nest_level3", 32'(cur_level), 32'd3);
        chk("nest_depth2", 32'(depth), 32'd2);
        pc_next = 32'h404; irq_req = 3'b010;
        step();
        irq_req = 3'b000; settle();
        chk("nest_masked_pend", 32'(pending), 32'b010);
        chk("nest_masked_redir", 32'(redirect), 32'd0);
        step();
        chk("nest_masked_level", 32'(cur_level), 32'd3);
        pc_next = 32'h408; uret = 1'b1; settle();
        chk("nest_ret_pc", redirect_pc, 32'h204);
        step();
        uret = 1'b0; pc_next = 32'h208; settle();
        chk("nest_ret_level", 32'(cur_level), 32'd1);
        chk("nest_ret_depth", 32'(depth), 32'd1);
        chk("nest_src1_vec", redirect_pc, 32'h300);
        step();
        chk("nest_src1_level", 32'(cur_level), 32'd2);
        chk("nest_src1_depth", 32'(depth), 32'd2);
        chk("nest_src1_pend", 32'(pending), 32'd0);
        uret = 1'b1; settle();
        chk("nest_unwind1", redirect_pc, 32'h208);
        step();
        settle();
        chk("nest_unwind2", redirect_pc, 32'h50);
        step();
        uret = 1'b0; settle();
        chk("nest_unwound_depth", 32'(depth), 32'd0);
        chk("nest_unwound_level", 32'(cur_level), 32'd0);

        // ecall collides with an eligible interrupt.
        pc_next = 32'h60; irq_req = 3'b001;
        step();
        irq_req = 3'b000; ecall = 1'b1; pc_next = 32'h80; settle();
        chk("sim_ecall_vec", redirect_pc, 32'h100);
        step();
        ecall = 1'b0; pc_next = 32'h104; settle();
        chk("sim_pend_kept", 32'(pending), 32'b001);
        chk("sim_depth1", 32'(depth), 32'd1);
        chk("sim_level0", 32'(cur_level), 32'd0);
        chk("sim_irq_vec", redirect_pc, 32'h200);
        step();
        chk("sim_depth2", 32'(depth), 32'd2);
        chk("sim_level1", 32'(cur_level), 32'd1);
        uret = 1'b1; settle();
        chk("sim_ret1", redirect_pc, 32'h104);
        step();
        settle();
        chk("sim_ret2", redirect_pc, 32'h80);
        chk("sim_ret2_level", 32'(cur_level), 32'd0);
        step();
        uret = 1'b0; settle();
        chk("sim_unwound", 32'(depth), 32'd0);

        // Overflow: four ecalls fill the stack, the fifth is a nop.
        ecall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pc_next = 32'(k * 16);
            step();
        end
        settle();
        chk("ovf_depth4", 32'(depth), 32'd4);
        chk("ovf_redirect", 32'(redirect), 32'd0);
        step();
        ecall = 1'b0; settle();
        chk("ovf_err", 32'(stack_err), 32'd1);
        chk("ovf_depth_hold", 32'(depth), 32'd4);
        uret = 1'b1; settle();
        chk("ovf_top_pc", redirect_pc, 32'h40);
        uret = 1'b0;

        // Asynchronous reset with state and a pending request.
        irq_en = 1'b0; irq_req = 3'b001;
        step();
        irq_req = 3'b000; settle();
        chk("prerst_pend", 32'(pending), 32'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_err", 32'(stack_err), 32'd0);
        chk("midrst_level", 32'(cur_level), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("postrst_pending", 32'(pending), 32'd0);

        // Underflow: uret at depth 0.
        uret = 1'b1; settle();
        chk("unf_redirect", 32'(redirect), 32'd0);
        step();
        uret = 1'b0; settle();
        chk("unf_err", 32'(stack_err), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        step();
        chk("unf_err_sticky", 32'(stack_err), 32'd1);

        // Gating: request latched while disabled, taken once enabled.
        irq_en = 1'b0; pc_next = 32'h90; irq_req = 3'b010;
        step();
        irq_req = 3'b000; settle();
        chk("gate_pend", 32'(pending), 32'b010);
        chk("gate_noredir", 32'(redirect), 32'd0);
        step();
        chk("gate_hold", 32'(depth), 32'd0);
        irq_en = 1'b1; settle();
        chk("gate_redir", 32'(redirect), 32'd1);
        chk("gate_vec", redirect_pc, 32'h300);
        step();
        chk("gate_level", 32'(cur_level), 32'd2);
        chk("gate_depth", 32'(depth), 32'd1);
        uret = 1'b1; settle();
        chk("gate_ret_pc", redirect_pc, 32'h90);
        step();
        uret = 1'b0;

        // Held request: one entry only, no re-pend while held.
        pc_next = 32'hA0; irq_req = 3'b010;
        for (int k = 0; k < 10; k++) step();
        irq_req = 3'b000; settle();
        chk("held_depth", 32'(depth), 32'd1);
        chk("held_level", 32'(cur_level), 32'd2);
        chk("held_pend", 32'(pending), 32'd0);
        uret = 1'b1; settle();
        chk("held_ret_pc", redirect_pc, 32'hA0);
        step();
        uret = 1'b0; settle();
        chk("held_unwound", 32'(depth), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, required completion");
        $fatal(1);
    end

endmodule

// File: doc/trap_unit.md
# trap_unit

Trap and return handler for the single-cycle RISC-V core; the sequential responder to the decoder's `ecall`/`uret` outputs and to three external interrupt lines. It latches interrupt edges, arbitrates by priority against the level currently in service, and supplies a PC redirect to the fetch mux. It also keeps a nested return stack of saved PCs and levels, so `uret` resumes at the correct point.

## Interface
Parameters:
- `ADDR_W`, 32, PC width.
- `ECALL_VEC`, 32'h0000_0100, ecall handler entry.
- `IRQ_VEC0`/`IRQ_VEC1`/`IRQ_VEC2`, 32'h0000_0200/0300/0400, handler entry per source.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `ecall` in 1 — current instruction is ecall (from decoder).
- `uret` in 1 — current instruction is uret (from decoder).
- `irq_req` in 3 — interrupt request lines; bit 2 is highest priority. Synchronous to `clk`.
- `irq_en` in 1 — global interrupt enable.
- `pc_next` in ADDR_W — sequential next PC of the current instruction.
- `redirect` out 1 — override fetch PC this cycle (combinational).
- `redirect_pc` out ADDR_W — target when `redirect`=1; 0 otherwise.
- `cur_level` out 2 — priority in service (0 = none; 1..3 = `irq_req[0..2]`).
- `pending` out 3 — latched, not yet taken requests.
- `depth` out 3 — return-stack occupancy, 0..4.
- `stack_err` out 1 — sticky overflow/underflow flag.

## Operation
- **Edge capture:** `irq_prev` registers `irq_req`. A rising edge on bit i (`irq_req[i] & ~irq_prev[i]`) sets `pending[i]`. `pending[i]` clears only when source i is taken; the edge has priority over the clear if both occur in one cycle.
- **Eligibility:** source i is eligible when `pending[i]` and `irq_en` are set, `i+1 > cur_level`, and `depth < 4`. The highest eligible i wins.
- **Event priority per cycle:** `uret` > `ecall` > interrupt. At most one event is accepted per cycle.
- **uret with `depth`>0:** `redirect`=1, `redirect_pc` = top of stack. On the edge: pop, and `cur_level` is restored from the popped entry.
- **uret with `depth`=0:** `redirect`=0, `stack_err` set, no state change.
- **ecall with `depth`<4:** `redirect`=1, `redirect_pc`=`ECALL_VEC`. Push {`pc_next`, `cur_level`}. `cur_level` is unchanged.
- **ecall with `depth`=4:** no redirect, `stack_err` set; the instruction behaves as a nop.
- **Interrupt taken (source i):** `redirect`=1, `redirect_pc`=`IRQ_VECi`. Push {`pc_next`, `cur_level`}, set `cur_level`=i+1, clear `pending[i]`. The current instruction completes; `pc_next` is the resume address.
- **Losing interrupts:** an eligible interrupt that loses to ecall/uret stays pending and is re-evaluated next cycle against the updated level.
- **Nested entry:** entering a handler does not mask interrupts. Nesting is limited only by level comparison and `depth`.
- **Stack:** 4 entries of {ADDR_W PC, 2-bit level}, LIFO, indexed by `depth`. Entries above `depth` are don't-care.
- **`stack_err`:** cleared only by reset.

## Timing
- **Reset values:** `pending`=0, `irq_prev`=0, `cur_level`=0, `depth`=0, `stack_err`=0, stack contents=0. Consequently `redirect`=0 and `redirect_pc`=0.
- **Reset mid-handler:** abandons all state immediately (asynchronous). No pending request survives.
- **Interrupt latency:** `irq_req` rises before edge t. `pending` is visible after edge t, and `redirect` is asserted in cycle t+1 (combinational from registered state). One-cycle latency.
- **Redirect timing:** `redirect`/`redirect_pc` are combinational from the current `ecall`, `uret`, `irq_en`, and registered state. Stack, level, and pending updates happen on the same rising edge that fetches from `redirect_pc`.
- **Held requests:** a request held high counts as one edge. A new pulse is needed to re-pend after it is taken.
- **Repeated pulses:** a second pulse on a source while it is pending is absorbed (no counting).
- **`irq_en`=0:** requests are still latched into `pending`; they are taken once `irq_en` returns to 1.
- **Back-to-back entry:** with multiple pendings, a higher source may pre-empt on the very first cycle of a lower handler.

## Test plan
- **Reset state:** reset mid-sequence → all outputs 0 the same cycle; `pending`=0 after release.
- **Single interrupt:** `irq_en`=1, pulse `irq_req[0]` at cycle 5, `pc_next`=0x40 → cycle 6 `redirect`=1, `redirect_pc`=0x200; then `cur_level`=1, `depth`=1. Later `uret` → `redirect_pc`=0x40, `cur_level`=0, `depth`=0.
- **Nesting and masking:** in level-1 handler, pulse `irq_req[2]` → `redirect_pc`=0x400, `cur_level`=3, `depth`=2. Then pulse `irq_req[1]` → stays pending (2 ≤ 3). After `uret`, `cur_level`=1 and source 1 is taken the next cycle with `redirect_pc`=0x300.
- **Simultaneous events:** `ecall` with `pc_next`=0x80 in the same cycle `pending[0]` is eligible → `redirect_pc`=0x100, `pending[0]` still 1. Next cycle `redirect_pc`=0x200 with stacked `pc_next` of that cycle; `depth`=2.
- **Stack limits:** four nested pushes → `depth`=4; fifth ecall gives `redirect`=0, `stack_err`=1. From `depth`=0, `uret` gives `redirect`=0, `stack_err`=1.
- **Gating and edges:** `irq_en`=0, pulse `irq_req[1]` → `pending`=3'b010 and no redirect. Raise `irq_en` → taken next cycle. Holding `irq_req[1]` high for 10 cycles produces exactly one entry.
